mem_be_pipe: RTL

//  Parametrised single-port synchronous RAM, successor to the basic mem block.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_be_pipe_if.sv | 33 +++
 rtl/mem_rd_pipe.sv | 46 ++++
 rtl/mem_be_pipe.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, limits and byte-merge helper for mem_be_pipe
// Purpose: FSM state type, parameter limits and the byte-enable merge
//          function used for both masked writes and read-during-write data.
// Ports:   none (package)
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LATENCY_MAX = 4;

  // be_merge works on a fixed wide word. Callers cast their DWIDTH word up
  // to this width and cast the result back down.
  localparam int DWIDTH_MAX  = 512;
  localparam int BEWIDTH_MAX = DWIDTH_MAX / 8;

  // Byte k of the result is new_w when be[k] is set, otherwise old_w.
  function automatic logic [DWIDTH_MAX-1:0] be_merge(
    input logic [DWIDTH_MAX-1:0]  old_w,
    input logic [DWIDTH_MAX-1:0]  new_w,
    input logic [BEWIDTH_MAX-1:0] be
  );
    logic [DWIDTH_MAX-1:0] res;
    res = '0;
    for (int k = 0; k < BEWIDTH_MAX; k++) begin
      res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_be_pipe_if.sv
// rtl/mem_be_pipe_if.sv - request/response bundle for mem_be_pipe
// Purpose: groups the memory-agent request strobes and response/status
//          outputs. master = agent side, slave = memory side.
// Signals: wr_i, be_i, rd_i, addr_i, data_i (agent -> memory)
//          rddata_o, rddatavalid_o, busy_o, drop_o (memory -> agent)
interface mem_be_pipe_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 6
);

  localparam int BEWIDTH = DWIDTH / 8;

  logic               wr_i;
  logic [BEWIDTH-1:0] be_i;
  logic               rd_i;
  logic [AWIDTH-1:0]  addr_i;
  logic [DWIDTH-1:0]  data_i;
  logic [DWIDTH-1:0]  rddata_o;
  logic               rddatavalid_o;
  logic               busy_o;
  logic               drop_o;

  modport master (
    output wr_i, be_i, rd_i, addr_i, data_i,
    input  rddata_o, rddatavalid_o, busy_o, drop_o
  );

  modport slave (
    input  wr_i, be_i, rd_i, addr_i, data_i,
    output rddata_o, rddatavalid_o, busy_o, drop_o
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - read valid/data delay line behind the array read register
// Purpose: delays the stage-0 read result by DEPTH further cycles, in order.
//          Synchronous flush on rst_i discards every in-flight read.
// Ports:   clk_i, rst_i       clock, synchronous active-high reset
//          valid_i, data_i    stage-0 read result
//          valid_o, data_o    delayed result (DEPTH cycles later)
module mem_rd_pipe #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][DWIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/mem_be_pipe.sv
// rtl/mem_be_pipe.sv - single-port RAM with byte enables, read pipeline and clear-after-reset
// Purpose: 2**AWIDTH x DWIDTH synchronous RAM. Per-byte writes, RD_LATENCY-cycle
//          reads (1 per cycle, in order), selectable read-during-write result,
//          optional hardware zero-fill after reset.
// Ports:   clk_i   clock, all logic on posedge
//          rst_i   synchronous active-high reset
//          bus     mem_be_pipe_if.slave: wr_i/be_i/rd_i/addr_i/data_i in,
//                  rddata_o/rddatavalid_o/busy_o/drop_o out
module mem_be_pipe
  import mem_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 6,
  parameter int RD_LATENCY   = 1,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_be_pipe_if.slave bus
);

  localparam int     BEWIDTH   = DWIDTH / 8;
  localparam int     NWORDS    = 2 ** AWIDTH;
  localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : READY;

  if ((DWIDTH % 8) != 0 || DWIDTH > DWIDTH_MAX ||
      RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_param_err
    $error("mem_be_pipe: DWIDTH must be a multiple of 8 and RD_LATENCY in 1..4");
  end

  logic [DWIDTH-1:0] mem_q [NWORDS];

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] clr_addr_q, clr_addr_d;
  logic              drop_q, drop_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;

  logic              ready, wr_fire, rd_fire;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata, cur_word, merged_word;
  logic              pipe_valid;
  logic [DWIDTH-1:0] pipe_data;

  assign ready       = (state_q == READY);
  assign wr_fire     = ready && bus.wr_i;
  assign rd_fire     = ready && bus.rd_i;
  assign cur_word    = mem_q[bus.addr_i];
  assign merged_word = DWIDTH'(be_merge(DWIDTH_MAX'(cur_word), DWIDTH_MAX'(bus.data_i),
                                        BEWIDTH_MAX'(bus.be_i)));

  // Clear FSM: one word per cycle, leaves CLEAR after the last word is written.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + AWIDTH'(1);
        if (clr_addr_q == {AWIDTH{1'b1}}) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  // Array write port is shared by the clear sequence and user writes.
  // Nothing is written while rst_i is high so reset alone never alters contents.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.addr_i;
    mem_wdata = merged_word;
    if (!rst_i) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
      end else if (wr_fire && (|bus.be_i)) begin
        mem_we = 1'b1;
      end
    end
  end

  // Stage-0 read register. Idle slots carry zero data so the output is 0 when not valid.
  // rd and wr always share an address, so a same-cycle write is always a collision.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = '0;
    if (rd_fire) begin
      rd_data_d = (RDW_MODE != 0 && wr_fire) ? merged_word : cur_word;
    end
    drop_d = !ready && (bus.rd_i || bus.wr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  if (RD_LATENCY > 1) begin : g_rd_pipe
    mem_rd_pipe #(
      .DWIDTH (DWIDTH),
      .DEPTH  (RD_LATENCY - 1)
    ) u_rd_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (rd_valid_q),
      .data_i  (rd_data_q),
      .valid_o (pipe_valid),
      .data_o  (pipe_data)
    );
  end else begin : g_rd_direct
    assign pipe_valid = rd_valid_q;
    assign pipe_data  = rd_data_q;
  end

  assign bus.rddata_o      = pipe_data;
  assign bus.rddatavalid_o = pipe_valid;
  assign bus.busy_o        = (state_q == CLEAR);
  assign bus.drop_o        = drop_q;

endmodule
